// File: rtl/vector_uram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vector_uram_arbiter_if
// Brief    : Requester-side bus of the URAM vector-store arbiter.
// Revision : 1.0
// ============================================================================
interface vector_uram_arbiter_if #(
  parameter int SIZE = 256,
  parameter int AW   = 6
);
  logic            wr_req;
  logic [AW-1:0]   wr_addr;
  logic [SIZE-1:0] wr_data;
  logic            wr_gnt;
  logic            rd_req;
  logic [AW-1:0]   rd_addr;
  logic [1:0]      rd_mod;
  logic            rd_gnt;
  logic            rd_done;
  logic [SIZE-1:0] rd_data;
  logic            busy;

  modport slave (
    input  wr_req, wr_addr, wr_data, rd_req, rd_addr, rd_mod,
    output wr_gnt, rd_gnt, rd_done, rd_data, busy
  );

  modport master (
    output wr_req, wr_addr, wr_data, rd_req, rd_addr, rd_mod,
    input  wr_gnt, rd_gnt, rd_done, rd_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/vector_uram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vector_uram_arbiter
// Brief    : Round-robin single-owner access sequencer for the URAM vector store.
// Revision : 1.0
// ============================================================================
module vector_uram_arbiter #(
  parameter int SIZE   = 256,
  parameter int AW     = 6,
  parameter int RD_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vector_uram_arbiter_if.slave bus,
  output logic [SIZE-1:0]      o_u_data_in,
  output logic [AW-1:0]        o_u_write_addr,
  output logic                 o_u_wr_en,
  output logic [AW-1:0]        o_u_read_addr,
  output logic                 o_u_en_read,
  output logic [1:0]           o_u_mod,
  input  logic [SIZE-1:0]      i_u_out_number
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WRITE    = 2'd1;
  localparam logic [1:0] S_RD_ISSUE = 2'd2;
  localparam logic [1:0] S_RD_WAIT  = 2'd3;

  localparam logic [3:0] c_CNT_LOAD = 4'(RD_LAT - 1);

  logic [1:0]      r_state;
  logic [1:0]      w_next;
  logic            r_last_rd;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_waddr;
  logic [SIZE-1:0] r_wdata;
  logic [AW-1:0]   r_raddr;
  logic [1:0]      r_mod;
  logic [SIZE-1:0] r_rd_data;

  logic w_pick_wr;
  logic w_pick_rd;
  logic w_cnt_zero;
  logic w_wr_gnt;
  logic w_rd_gnt;
  logic w_rd_done;
  logic w_busy;
  logic w_wr_en;
  logic w_en_read;

  // On contention the side that did not win last time gets the grant.
  assign w_pick_wr  = bus.wr_req & (~bus.rd_req | r_last_rd);
  assign w_pick_rd  = bus.rd_req & (~bus.wr_req | ~r_last_rd);
  assign w_cnt_zero = (r_cnt == 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_pick_wr) begin
          w_next = S_WRITE;
        end else if (w_pick_rd) begin
          w_next = S_RD_ISSUE;
        end
      end
      S_WRITE:    w_next = S_IDLE;
      S_RD_ISSUE: w_next = S_RD_WAIT;
      S_RD_WAIT: begin
        if (w_cnt_zero) begin
          w_next = S_IDLE;
        end
      end
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_wr_gnt  = 1'b0;
    w_wr_en   = 1'b0;
    w_rd_gnt  = 1'b0;
    w_en_read = 1'b0;
    w_rd_done = 1'b0;
    w_busy    = (r_state != S_IDLE);
    case (r_state)
      S_WRITE: begin
        w_wr_gnt = 1'b1;
        w_wr_en  = 1'b1;
      end
      S_RD_ISSUE: begin
        w_rd_gnt  = 1'b1;
        w_en_read = 1'b1;
      end
      S_RD_WAIT: w_rd_done = w_cnt_zero;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_rd <= 1'b1;
      r_cnt     <= 4'd0;
      r_waddr   <= '0;
      r_wdata   <= '0;
      r_raddr   <= '0;
      r_mod     <= 2'd0;
      r_rd_data <= '0;
    end else begin
      if (r_state == S_IDLE) begin
        if (w_pick_wr) begin
          r_last_rd <= 1'b0;
          r_waddr   <= bus.wr_addr;
          r_wdata   <= bus.wr_data;
        end else if (w_pick_rd) begin
          r_last_rd <= 1'b1;
          r_raddr   <= bus.rd_addr;
          r_mod     <= bus.rd_mod;
        end
      end
      if (r_state == S_RD_ISSUE) begin
        r_cnt <= c_CNT_LOAD;
      end else if ((r_state == S_RD_WAIT) && !w_cnt_zero) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_rd_done) begin
        r_rd_data <= i_u_out_number;
      end
    end
  end

  // The store word is forwarded during the done cycle so rd_data is valid with rd_done.
  assign bus.rd_data = w_rd_done ? i_u_out_number : r_rd_data;
  assign bus.wr_gnt  = w_wr_gnt;
  assign bus.rd_gnt  = w_rd_gnt;
  assign bus.rd_done = w_rd_done;
  assign bus.busy    = w_busy;

  assign o_u_data_in    = r_wdata;
  assign o_u_write_addr = r_waddr;
  assign o_u_wr_en      = w_wr_en;
  assign o_u_read_addr  = r_raddr;
  assign o_u_en_read    = w_en_read;
  assign o_u_mod        = r_mod;

endmodule
`default_nettype wire

// File: tb/tb_vector_uram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// Scoreboard bench for vector_uram_arbiter: requester tasks push expected grants,
// a negedge monitor pops and compares; a behavioural store answers reads after RD_LAT.
module tb_vector_uram_arbiter;
  localparam int SIZE   = 256;
  localparam int AW     = 6;
  localparam int RD_LAT = 4;

  typedef struct {
    bit              is_rd;
    logic [AW-1:0]   addr;
    logic [SIZE-1:0] data;
    logic [1:0]      mod;
  } ev_t;

  typedef struct {
    logic [SIZE-1:0] val;
    int              issue;
    logic [AW-1:0]   addr;
    logic [1:0]      mod;
  } rd_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vector_uram_arbiter_if #(.SIZE(SIZE), .AW(AW)) bus ();

  logic [SIZE-1:0] u_data_in;
  logic [AW-1:0]   u_write_addr;
  logic            u_wr_en;
  logic [AW-1:0]   u_read_addr;
  logic            u_en_read;
  logic [1:0]      u_mod;
  logic [SIZE-1:0] u_out_number;

  vector_uram_arbiter #(.SIZE(SIZE), .AW(AW), .RD_LAT(RD_LAT)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .o_u_data_in   (u_data_in),
    .o_u_write_addr(u_write_addr),
    .o_u_wr_en     (u_wr_en),
    .o_u_read_addr (u_read_addr),
    .o_u_en_read   (u_en_read),
    .o_u_mod       (u_mod),
    .i_u_out_number(u_out_number)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t             expq[$];
  rd_t             rdq[$];
  logic [SIZE-1:0] shadow    [0:(1<<AW)-1];
  logic [SIZE-1:0] store_mem [0:(1<<AW)-1];
  bit              last_rd = 1'b1;
  logic [SIZE-1:0] held = '0;
  int              n_wgnt = 0;
  int              n_done = 0;

  function automatic logic [SIZE-1:0] rnd_word();
    logic [SIZE-1:0] v;
    for (int i = 0; i < SIZE / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic chk(input string name, input logic [SIZE-1:0] act, input logic [SIZE-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Reference: a write commits immediately in grant order; a read returns the
  // last committed word at that address plus the mode; grants alternate.
  function automatic ev_t mk_w(input logic [AW-1:0] a, input logic [SIZE-1:0] d);
    ev_t e;
    e.is_rd = 1'b0; e.addr = a; e.data = d; e.mod = 2'd0;
    shadow[a] = d;
    last_rd = 1'b0;
    return e;
  endfunction

  function automatic ev_t mk_r(input logic [AW-1:0] a, input logic [1:0] m);
    ev_t e;
    e.is_rd = 1'b1; e.addr = a; e.mod = m;
    e.data = shadow[a] + SIZE'(m);
    last_rd = 1'b1;
    return e;
  endfunction

  // Behavioural store: word valid exactly RD_LAT cycles after the en_read cycle, garbage otherwise.
  int              sm_cnt;
  logic [SIZE-1:0] sm_val;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sm_cnt       <= 0;
      u_out_number <= '0;
    end else begin
      if (u_wr_en) store_mem[u_write_addr] <= u_data_in;
      if (u_en_read) begin
        if (RD_LAT == 1) begin
          u_out_number <= store_mem[u_read_addr] + SIZE'(u_mod);
        end else begin
          sm_val       <= store_mem[u_read_addr] + SIZE'(u_mod);
          sm_cnt       <= 1;
          u_out_number <= rnd_word();
        end
      end else if (sm_cnt != 0 && sm_cnt + 1 == RD_LAT) begin
        u_out_number <= sm_val;
        sm_cnt       <= 0;
      end else begin
        u_out_number <= rnd_word();
        if (sm_cnt != 0) sm_cnt <= sm_cnt + 1;
      end
    end
  end

  always @(negedge clk) begin : monitor
    ev_t e;
    rd_t r;
    if (rst_n) begin
      if (bus.wr_gnt || bus.rd_gnt || u_wr_en || u_en_read)
        chk("strobe_vs_gnt", SIZE'({u_wr_en, u_en_read}), SIZE'({bus.wr_gnt, bus.rd_gnt}));
      if (bus.wr_gnt) begin
        n_wgnt++;
        if (expq.size() == 0) fail_now("unexpected_wr_gnt");
        else begin
          e = expq.pop_front();
          chk("grant_kind_at_wr_gnt", SIZE'(1'b0), SIZE'(e.is_rd));
          chk("u_write_addr", SIZE'(u_write_addr), SIZE'(e.addr));
          chk("u_data_in", u_data_in, e.data);
          chk("busy_in_write", SIZE'(bus.busy), SIZE'(1'b1));
        end
      end
      if (bus.rd_gnt) begin
        if (expq.size() == 0) fail_now("unexpected_rd_gnt");
        else begin
          e = expq.pop_front();
          chk("grant_kind_at_rd_gnt", SIZE'(1'b1), SIZE'(e.is_rd));
          chk("u_read_addr", SIZE'(u_read_addr), SIZE'(e.addr));
          chk("u_mod", SIZE'(u_mod), SIZE'(e.mod));
          chk("rd_data_held", bus.rd_data, held);
          r.val = e.data; r.issue = cyc; r.addr = e.addr; r.mod = e.mod;
          rdq.push_back(r);
        end
      end
      if (bus.rd_done) begin
        n_done++;
        if (rdq.size() == 0) fail_now("unexpected_rd_done");
        else begin
          r = rdq.pop_front();
          chk("rd_latency", SIZE'(cyc - r.issue), SIZE'(RD_LAT));
          chk("rd_data", bus.rd_data, r.val);
          chk("u_read_addr_stable", SIZE'(u_read_addr), SIZE'(r.addr));
          chk("u_mod_stable", SIZE'(u_mod), SIZE'(r.mod));
          held = r.val;
        end
      end
    end
  end

  task automatic wait_gnt(input bit rd, output int at, output bit ok);
    ok = 1'b0;
    at = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rd ? bus.rd_gnt : bus.wr_gnt) begin
        ok = 1'b1;
        at = cyc;
        break;
      end
    end
    if (!ok) fail_now(rd ? "timeout_rd_gnt" : "timeout_wr_gnt");
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rdq.size() == 0 && expq.size() == 0 && !bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_now("timeout_idle");
  endtask

  // Caller guarantees the arbiter is idle, so the grant comes one cycle after the request cycle.
  task automatic do_write(input logic [AW-1:0] a, input logic [SIZE-1:0] d);
    int start, at;
    bit ok;
    @(posedge clk); #1;
    bus.wr_req = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    start = cyc;
    expq.push_back(mk_w(a, d));
    wait_gnt(1'b0, at, ok);
    if (ok) chk("wr_latency", SIZE'(at - start), SIZE'(1));
    @(posedge clk); #1;
    bus.wr_req = 1'b0; bus.wr_data = rnd_word();
    @(negedge clk);
    chk("busy_after_write", SIZE'(bus.busy), SIZE'(1'b0));
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [1:0] m, input bit pulse_wr);
    int start, at, wg0;
    bit ok;
    @(posedge clk); #1;
    bus.rd_req = 1'b1; bus.rd_addr = a; bus.rd_mod = m;
    start = cyc;
    expq.push_back(mk_r(a, m));
    wait_gnt(1'b1, at, ok);
    if (ok) chk("rd_latency_to_gnt", SIZE'(at - start), SIZE'(1));
    @(posedge clk); #1;
    bus.rd_req = 1'b0; bus.rd_addr = AW'(a + 2); bus.rd_mod = ~m;
    wg0 = n_wgnt;
    if (pulse_wr) begin
      bus.wr_req = 1'b1; bus.wr_addr = AW'($urandom); bus.wr_data = rnd_word();
      @(posedge clk); #1;
      bus.wr_req = 1'b0;
    end
    wait_idle();
    if (pulse_wr) chk("ignored_wr_while_busy", SIZE'(n_wgnt), SIZE'(wg0));
  endtask

  task automatic contend(input int n);
    ev_t wq[$];
    ev_t rq[$];
    ev_t e;
    bit gw, gr, ok;
    for (int k = 0; k < n; k++) begin
      if (last_rd) e = mk_w(AW'($urandom_range(0, 7)), rnd_word());
      else         e = mk_r(AW'($urandom_range(0, 7)), 2'($urandom));
      expq.push_back(e);
      if (e.is_rd) rq.push_back(e); else wq.push_back(e);
    end
    @(posedge clk); #1;
    if (wq.size() > 0) begin bus.wr_req = 1'b1; bus.wr_addr = wq[0].addr; bus.wr_data = wq[0].data; end
    if (rq.size() > 0) begin bus.rd_req = 1'b1; bus.rd_addr = rq[0].addr; bus.rd_mod = rq[0].mod; end
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (wq.size() == 0 && rq.size() == 0) begin ok = 1'b1; break; end
      @(negedge clk);
      gw = bus.wr_gnt;
      gr = bus.rd_gnt;
      if (gw || gr) begin
        @(posedge clk); #1;
        if (gw && wq.size() > 0) begin
          void'(wq.pop_front());
          if (wq.size() > 0) begin bus.wr_addr = wq[0].addr; bus.wr_data = wq[0].data; end
          else bus.wr_req = 1'b0;
        end
        if (gr && rq.size() > 0) begin
          void'(rq.pop_front());
          if (rq.size() > 0) begin bus.rd_addr = rq[0].addr; bus.rd_mod = rq[0].mod; end
          else begin bus.rd_req = 1'b0; bus.rd_addr = AW'($urandom); bus.rd_mod = 2'($urandom); end
        end
      end
    end
    if (!ok) fail_now("timeout_contention");
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    wait_idle();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ctrl"}, SIZE'({bus.wr_gnt, bus.rd_gnt, bus.rd_done, bus.busy, u_wr_en, u_en_read, u_mod}), '0);
    chk({tag, "_addrs"}, SIZE'({u_write_addr, u_read_addr}), '0);
    chk({tag, "_rd_data"}, bus.rd_data, '0);
    chk({tag, "_u_data_in"}, u_data_in, '0);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int snap;
    int at;
    bit ok;
    for (int i = 0; i < (1 << AW); i++) begin
      shadow[i] = '0;
      store_mem[i] = '0;
    end
    bus.wr_req = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_req = 1'b0; bus.rd_addr = '0; bus.rd_mod = 2'd0;
    rst_n = 1'b0;
    #20;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_write(6'h01, 256'h0000ffff);
    do_write(6'h22, 256'h12345676);
    do_read(6'h22, 2'd2, 1'b0);
    chk("rd_data_after_done", bus.rd_data, 256'h12345678);

    contend(3);
    do_read(6'h05, 2'd1, 1'b1);

    // Abandon a read two cycles after its en_read.
    @(posedge clk); #1;
    bus.rd_req = 1'b1; bus.rd_addr = 6'h22; bus.rd_mod = 2'd2;
    expq.push_back(mk_r(6'h22, 2'd2));
    wait_gnt(1'b1, at, ok);
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midread_reset");
    expq.delete();
    rdq.delete();
    held = '0;
    last_rd = 1'b1;
    snap = n_done;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (RD_LAT + 4) @(negedge clk);
    chk("no_done_after_reset", SIZE'(n_done), SIZE'(snap));
    do_read(6'h22, 2'd3, 1'b0);
    contend(2);

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: do_write(AW'($urandom_range(0, 7)), rnd_word());
        1: do_read(AW'($urandom_range(0, 7)), 2'($urandom), 1'($urandom));
        2: contend($urandom_range(2, 5));
        default: repeat ($urandom_range(1, 4)) @(posedge clk);
      endcase
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
